// File: rtl/matrix_result_printer.sv
// matrix_result_printer: streams a BRAM result matrix to a UART as ASCII decimal rows; define MATRIX_PRINT_SIGNED_EN for two's complement elements
module matrix_result_printer #(
    parameter int ELEMENT_WIDTH = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int MAX_DIM = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDR_WIDTH-1:0]    base_addr,
    input  logic [3:0]               dim_m,
    input  logic [3:0]               dim_n,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic                     mem_rd_en,
    output logic [ADDR_WIDTH-1:0]    mem_rd_addr,
    input  logic [ELEMENT_WIDTH-1:0] mem_rd_data,
    output logic [7:0]               tx_data,
    output logic                     tx_start,
    input  logic                     tx_busy
);
`ifdef MATRIX_PRINT_SIGNED_EN
    localparam int QD = 6;
    logic [7:0] sx;
    assign sx = 8'(signed'(mem_rd_data));
`else
    localparam int QD = 5;
`endif
    typedef enum logic [3:0] {IDLE, CHECK, RD_REQ, RD_WAIT, CONV, EMIT, TX_GUARD, TX_WAIT, DONE} state_t;
    state_t state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d, idx_q, idx_d;
    logic [3:0] m_q, m_d, n_q, n_d, row_q, row_d, col_q, col_d, ten_q, ten_d;
    logic [7:0] val_q, val_d;
    logic [1:0] hun_q, hun_d;
    logic neg_q, neg_d, err_q, err_d, done_q, done_d, last_col;
    logic [7:0] q_q [QD];
    logic [7:0] q_d [QD];
    logic [2:0] len_q, len_d, k;
    assign busy = state_q != IDLE && state_q != DONE;
    assign done = done_q;
    assign err = err_q;
    // state and datapath registers, all cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            base_q <= '0;
            idx_q <= '0;
            m_q <= '0;
            n_q <= '0;
            row_q <= '0;
            col_q <= '0;
            ten_q <= '0;
            val_q <= '0;
            hun_q <= '0;
            neg_q <= 1'b0;
            err_q <= 1'b0;
            done_q <= 1'b0;
            q_q <= '{default: '0};
            len_q <= '0;
        end else begin
            state_q <= state_d;
            base_q <= base_d;
            idx_q <= idx_d;
            m_q <= m_d;
            n_q <= n_d;
            row_q <= row_d;
            col_q <= col_d;
            ten_q <= ten_d;
            val_q <= val_d;
            hun_q <= hun_d;
            neg_q <= neg_d;
            err_q <= err_d;
            done_q <= done_d;
            q_q <= q_d;
            len_q <= len_d;
        end
    end
    // sequencing: read one element, convert by repeated subtraction, queue its bytes, drain them to the UART
    always_comb begin
        state_d = state_q;
        base_d = base_q;
        idx_d = idx_q;
        m_d = m_q;
        n_d = n_q;
        row_d = row_q;
        col_d = col_q;
        ten_d = ten_q;
        val_d = val_q;
        hun_d = hun_q;
        neg_d = neg_q;
        err_d = err_q;
        done_d = 1'b0;
        q_d = q_q;
        len_d = len_q;
        k = 3'd0;
        mem_rd_en = 1'b0;
        mem_rd_addr = '0;
        tx_data = 8'h00;
        tx_start = 1'b0;
        last_col = col_q == n_q - 4'd1;
        case (state_q)
            IDLE: if (start) begin
                base_d = base_addr;
                m_d = dim_m;
                n_d = dim_n;
                err_d = 1'b0;
                idx_d = '0;
                row_d = '0;
                col_d = '0;
                state_d = CHECK;
            end
            CHECK: begin
                err_d = m_q == 4'd0 || n_q == 4'd0 || 32'(m_q) > MAX_DIM || 32'(n_q) > MAX_DIM;
                state_d = err_d ? DONE : RD_REQ;
            end
            RD_REQ: begin
                mem_rd_en = 1'b1;
                mem_rd_addr = base_q + idx_q;
                hun_d = '0;
                ten_d = '0;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
`ifdef MATRIX_PRINT_SIGNED_EN
                neg_d = mem_rd_data[ELEMENT_WIDTH-1];
                val_d = neg_d ? ~sx + 8'd1 : sx;
`else
                neg_d = 1'b0;
                val_d = 8'(mem_rd_data);
`endif
                state_d = CONV;
            end
            CONV: if (val_q >= 8'd100) begin
                val_d = val_q - 8'd100;
                hun_d = hun_q + 2'd1;
            end else if (val_q >= 8'd10) begin
                val_d = val_q - 8'd10;
                ten_d = ten_q + 4'd1;
            end else begin
                if (neg_q) begin
                    q_d[k] = 8'h2D;
                    k = k + 3'd1;
                end
                if (hun_q != 2'd0) begin
                    q_d[k] = 8'h30 + 8'(hun_q);
                    k = k + 3'd1;
                end
                if (hun_q != 2'd0 || ten_q != 4'd0) begin
                    q_d[k] = 8'h30 + 8'(ten_q);
                    k = k + 3'd1;
                end
                q_d[k] = 8'h30 + val_q;
                k = k + 3'd1;
                if (last_col) begin
                    q_d[k] = 8'h0D;
                    q_d[k+3'd1] = 8'h0A;
                    k = k + 3'd2;
                end else begin
                    q_d[k] = 8'h20;
                    k = k + 3'd1;
                end
                len_d = k;
                state_d = EMIT;
            end
            EMIT: if (!tx_busy) begin
                tx_start = 1'b1;
                tx_data = q_q[0];
                for (int i = 0; i < QD - 1; i++) q_d[i] = q_q[i+1];
                q_d[QD-1] = 8'h00;
                len_d = len_q - 3'd1;
                state_d = TX_GUARD;
            end
            TX_GUARD: state_d = TX_WAIT;
            TX_WAIT: if (!tx_busy) begin
                if (len_q != 3'd0) state_d = EMIT;
                else begin
                    idx_d = idx_q + 1'b1;
                    col_d = last_col ? 4'd0 : col_q + 4'd1;
                    row_d = last_col ? row_q + 4'd1 : row_q;
                    state_d = last_col && row_q == m_q - 4'd1 ? DONE : RD_REQ;
                end
            end
            DONE: begin
                done_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_matrix_result_printer.sv
// tb_matrix_result_printer: randomized self-checking bench comparing the byte stream against a printf-based reference
module tb_matrix_result_printer;
    localparam int AW = 10;
    localparam int MEMN = 1 << AW;
    logic clk, rst, start, busy, done, err, mem_rd_en, tx_start, tx_busy;
    logic [AW-1:0] base_addr, mem_rd_addr;
    logic [3:0] dim_m, dim_n;
    logic [7:0] mem_rd_data, tx_data;
    logic [7:0] mem [MEMN];
    int busy_len, busy_cnt, cyc_n, start_cyc, done_cyc, done_cnt, done0, viol;
    int tests_run, fails;
    bit err_at_done, prev_rd;
    logic [7:0] rx[$];
    int rd_log[$], rd_cyc[$], tx_cyc[$];

    matrix_result_printer dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .dim_m(dim_m), .dim_n(dim_n),
        .busy(busy), .done(done), .err(err), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data), .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    // BRAM with one-cycle read latency; data is garbage in every other cycle
    always @(posedge clk) mem_rd_data <= mem_rd_en ? mem[mem_rd_addr] : 8'($urandom);

    // UART: busy for busy_len cycles after each accepted strobe
    always @(posedge clk)
        if (tx_start && !tx_busy) busy_cnt <= busy_len;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    assign tx_busy = busy_cnt != 0;

    // observation away from the active edge
    always @(negedge clk) begin
        cyc_n++;
        if (mem_rd_en) begin
            rd_log.push_back(int'(mem_rd_addr));
            rd_cyc.push_back(cyc_n);
            if (tx_busy || prev_rd) viol++;
        end
        prev_rd = mem_rd_en;
        if (tx_start) begin
            rx.push_back(tx_data);
            tx_cyc.push_back(cyc_n);
            if (tx_busy) viol++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc_n;
            err_at_done = err;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic string model(input int b, input int m, input int n);
        string s;
        logic [7:0] v;
        s = "";
        for (int r = 0; r < m; r++)
            for (int c = 0; c < n; c++) begin
                v = mem[(b + r * n + c) % MEMN];
`ifdef MATRIX_PRINT_SIGNED_EN
                s = {s, $sformatf("%0d", $signed(v))};
`else
                s = {s, $sformatf("%0d", v)};
`endif
                if (c == n - 1) s = {s, "\015\012"};
                else s = {s, " "};
            end
        return s;
    endfunction

    function automatic int first_diff(input string s);
        int n;
        n = rx.size() > s.len() ? rx.size() : s.len();
        for (int i = 0; i < n; i++)
            if (i >= rx.size() || i >= s.len() || rx[i] != s[i]) return i;
        return -1;
    endfunction

    function automatic int rd_diff(input int b, input int cnt);
        int n;
        n = rd_log.size() > cnt ? rd_log.size() : cnt;
        for (int i = 0; i < n; i++)
            if (i >= rd_log.size() || i >= cnt || rd_log[i] != (b + i) % MEMN) return i;
        return -1;
    endfunction

    function automatic void fill(input int b, input int cnt);
        int pick[7] = '{0, 9, 10, 99, 100, 199, 255};
        for (int i = 0; i < cnt; i++)
            mem[(b + i) % MEMN] = $urandom_range(0, 2) == 0 ? 8'(pick[$urandom_range(0, 6)]) : 8'($urandom);
    endfunction

    task automatic launch(input int b, input int m, input int n);
        rx.delete();
        rd_log.delete();
        rd_cyc.delete();
        tx_cyc.delete();
        viol = 0;
        base_addr = AW'(b);
        dim_m = 4'(m);
        dim_n = 4'(n);
        start = 1'b1;
        start_cyc = cyc_n;
        done0 = done_cnt;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 0;
        for (int i = 0; i < 20000; i++) begin
            if (done_cnt != done0) begin
                ok = 1;
                break;
            end
            step();
        end
        tests_run++;
        if (!ok) begin
            fails++;
            $display("FAIL wait_done: no done within 20000 cycles (done count %0d, expected %0d)", done_cnt, done0 + 1);
        end
        step();
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        base_addr = 5;
        dim_m = 2;
        dim_n = 2;
        repeat (3) step();
        tests_run++;
        if ({busy, done, err, mem_rd_en, tx_start, mem_rd_addr, tx_data} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: busy%b done%b err%b rd%b txs%b addr%0d txd%02h, all required zero", busy, done, err, mem_rd_en, tx_start, mem_rd_addr, tx_data);
        end
        rst = 1'b0;
        start = 1'b0;
        step();
        tests_run++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_start_override: busy=%b, required 0", busy);
        end
        repeat (3) step();
        tests_run++;
        if ({busy, done, err, mem_rd_en, tx_start, mem_rd_addr, tx_data} !== '0) begin
            fails++;
            $display("FAIL idle_outputs: busy%b done%b err%b rd%b txs%b addr%0d txd%02h, all required zero", busy, done, err, mem_rd_en, tx_start, mem_rd_addr, tx_data);
        end
    endtask

    task automatic test_basic();
        int b, d, lat_rd, lat_tx;
        b = $urandom_range(0, MEMN - 5);
        mem[b] = 1; mem[b+1] = 20; mem[b+2] = 3; mem[b+3] = 255;
        busy_len = 0;
        launch(b, 2, 2);
        wait_done();
        d = first_diff("1 20\015\0123 255\015\012");
        tests_run++;
        if (d != -1) begin
            fails++;
            $display("FAIL basic_stream: got %0d bytes, required 13, first difference at byte %0d", rx.size(), d);
        end
        tests_run++;
        if (done_cnt - done0 != 1 || err_at_done !== 1'b0) begin
            fails++;
            $display("FAIL basic_done: done pulses %0d err %b, required 1 and 0", done_cnt - done0, err_at_done);
        end
        d = rd_diff(b, 4);
        tests_run++;
        if (d != -1) begin
            fails++;
            $display("FAIL basic_reads: %0d reads, first wrong at %0d, required 4 at base %0d", rd_log.size(), d, b);
        end
        lat_rd = rd_cyc.size() == 0 ? -1 : rd_cyc[0] - start_cyc;
        tests_run++;
        if (lat_rd != 2) begin
            fails++;
            $display("FAIL basic_rd_latency: first read in cycle %0d, required 2", lat_rd);
        end
        lat_tx = tx_cyc.size() == 0 ? 999 : tx_cyc[0] - start_cyc;
        tests_run++;
        if (lat_tx > 17) begin
            fails++;
            $display("FAIL basic_tx_latency: first tx_start in cycle %0d, required <= 17", lat_tx);
        end
        tests_run++;
        if (viol != 0) begin
            fails++;
            $display("FAIL basic_protocol: %0d violations, required 0", viol);
        end
    endtask

    task automatic test_zero_wrap();
        int d;
        mem[MEMN-1] = 0; mem[0] = 100; mem[1] = 9;
        busy_len = 1;
        launch(MEMN - 1, 1, 3);
        wait_done();
        d = first_diff("0 100 9\015\012");
        tests_run++;
        if (d != -1) begin
            fails++;
            $display("FAIL wrap_stream: got %0d bytes, required 9, first difference at byte %0d", rx.size(), d);
        end
        d = rd_diff(MEMN - 1, 3);
        tests_run++;
        if (d != -1) begin
            fails++;
            $display("FAIL wrap_reads: %0d reads, first wrong at %0d, required %0d,0,1", rd_log.size(), d, MEMN - 1);
        end
    endtask

    task automatic test_illegal();
        int dm[4] = '{0, 2, 6, 15};
        int dn[4] = '{2, 6, 1, 3};
        for (int i = 0; i < 4; i++) begin
            launch($urandom_range(0, MEMN - 1), dm[i], dn[i]);
            wait_done();
            tests_run++;
            if (done_cyc - start_cyc != 3 || err_at_done !== 1'b1) begin
                fails++;
                $display("FAIL illegal_%0dx%0d_done: done in cycle %0d err %b, required cycle 3 err 1", dm[i], dn[i], done_cyc - start_cyc, err_at_done);
            end
            tests_run++;
            if (rd_log.size() != 0 || rx.size() != 0) begin
                fails++;
                $display("FAIL illegal_%0dx%0d_quiet: %0d reads %0d bytes, required 0 and 0", dm[i], dn[i], rd_log.size(), rx.size());
            end
            tests_run++;
            if (err !== 1'b1) begin
                fails++;
                $display("FAIL illegal_%0dx%0d_err_hold: err=%b in idle, required 1", dm[i], dn[i], err);
            end
        end
        fill(0, 1);
        launch(0, 1, 1);
        tests_run++;
        if (err !== 1'b0) begin
            fails++;
            $display("FAIL err_clear: err=%b after accepted start, required 0", err);
        end
        wait_done();
    endtask

    task automatic test_random();
        int b, m, n, d;
        for (int t = 0; t < 5; t++) begin
            b = $urandom_range(0, MEMN - 1);
            m = $urandom_range(1, 5);
            n = $urandom_range(1, 5);
            busy_len = $urandom_range(0, 3);
            fill(b, m * n);
            launch(b, m, n);
            wait_done();
            d = first_diff(model(b, m, n));
            tests_run++;
            if (d != -1) begin
                fails++;
                $display("FAIL random_%0dx%0d_stream: got %0d bytes, required %0d, first difference at byte %0d", m, n, rx.size(), model(b, m, n).len(), d);
            end
            d = rd_diff(b, m * n);
            tests_run++;
            if (d != -1 || viol != 0 || err_at_done !== 1'b0) begin
                fails++;
                $display("FAIL random_%0dx%0d_reads: %0d reads first wrong %0d, violations %0d, err %b; required %0d reads, -1, 0, 0", m, n, rd_log.size(), d, viol, err_at_done, m * n);
            end
        end
    endtask

    task automatic test_backpressure();
        int b, d;
        b = $urandom_range(0, MEMN - 1);
        fill(b, 6);
        busy_len = 50;
        launch(b, 2, 3);
        wait_done();
        d = first_diff(model(b, 2, 3));
        tests_run++;
        if (d != -1) begin
            fails++;
            $display("FAIL bp_stream: got %0d bytes, required %0d, first difference at byte %0d", rx.size(), model(b, 2, 3).len(), d);
        end
        tests_run++;
        if (viol != 0) begin
            fails++;
            $display("FAIL bp_protocol: %0d strobes or reads during busy, required 0", viol);
        end
        busy_len = 0;
    endtask

    task automatic test_start_ignored();
        int b, d;
        bit ok;
        b = $urandom_range(0, MEMN - 1);
        fill(b, 9);
        busy_len = 2;
        launch(b, 3, 3);
        ok = 0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            ok = rd_log.size() >= 2;
            if (!ok) step();
        end
        base_addr = AW'(b + 7);
        dim_m = 1;
        dim_n = 1;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done();
        d = first_diff(model(b, 3, 3));
        tests_run++;
        if (d != -1 || rd_diff(b, 9) != -1) begin
            fails++;
            $display("FAIL start_ignored_stream: %0d bytes first diff %0d, %0d reads; required %0d bytes and 9 reads", rx.size(), d, rd_log.size(), model(b, 3, 3).len());
        end
        repeat (10) step();
        tests_run++;
        if (busy !== 1'b0 || done_cnt - done0 != 1) begin
            fails++;
            $display("FAIL start_ignored_idle: busy %b done pulses %0d, required 0 and 1", busy, done_cnt - done0);
        end
    endtask

    task automatic test_reset_mid();
        int b, d;
        bit ok;
        b = $urandom_range(0, MEMN - 5);
        mem[b] = 1; mem[b+1] = 20; mem[b+2] = 3; mem[b+3] = 255;
        busy_len = 2;
        launch(b, 2, 2);
        ok = 0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            ok = rx.size() >= 3;
            if (!ok) step();
        end
        tests_run++;
        if (!ok) begin
            fails++;
            $display("FAIL reset_mid_wait: %0d bytes seen within bound, required 3", rx.size());
        end
        rst = 1'b1;
        step();
        tests_run++;
        if ({busy, done, err, mem_rd_en, tx_start, mem_rd_addr, tx_data} !== '0) begin
            fails++;
            $display("FAIL reset_mid_outputs: busy%b done%b err%b rd%b txs%b addr%0d txd%02h, all required zero", busy, done, err, mem_rd_en, tx_start, mem_rd_addr, tx_data);
        end
        rst = 1'b0;
        repeat (40) step();
        tests_run++;
        if (rx.size() != 3 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_abort: %0d bytes busy %b, required 3 and 0", rx.size(), busy);
        end
        launch(b, 2, 2);
        wait_done();
        d = first_diff("1 20\015\0123 255\015\012");
        tests_run++;
        if (d != -1) begin
            fails++;
            $display("FAIL reset_mid_reprint: got %0d bytes, required 13, first difference at byte %0d", rx.size(), d);
        end
    endtask

    task automatic test_extremes();
        int d;
        mem[300] = 8'hFF;
        mem[301] = 8'h80;
        busy_len = 0;
        launch(300, 1, 2);
        wait_done();
`ifdef MATRIX_PRINT_SIGNED_EN
        d = first_diff("-1 -128\015\012");
`else
        d = first_diff("255 128\015\012");
`endif
        tests_run++;
        if (d != -1) begin
            fails++;
            $display("FAIL extremes_stream: got %0d bytes, first difference at byte %0d", rx.size(), d);
        end
    endtask

    initial begin
        clk = 0;
        rst = 1;
        start = 0;
        base_addr = 0;
        dim_m = 0;
        dim_n = 0;
        busy_len = 0;
        busy_cnt = 0;
        cyc_n = 0;
        done_cnt = 0;
        viol = 0;
        tests_run = 0;
        fails = 0;
        prev_rd = 0;
        for (int i = 0; i < MEMN; i++) mem[i] = 8'($urandom);
        test_reset();
        test_basic();
        test_zero_wrap();
        test_illegal();
        test_random();
        test_backpressure();
        test_start_ignored();
        test_reset_mid();
        test_extremes();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
